scalar_mul_sequencer: RTL
=========================

// Module: scalar_mul_sequencer
// PURPOSE
//  Double-and-add controller for k*P. Scans scalar k MSB-first; sequences one shared
//  point_double and one shared point_add engine (instantiated outside, in the parent) via
//  their Reset-as-start / Done handshake. Tracks the point at infinity with a flag, not an
//  encoding. Replaces repeated-addition k*P in the MSM datapath with O(log k) engine ops.
// PARAMETERS
//  SCALAR_W   256     width of k
//  TIMEOUT    65535   max cycles waiting on one engine Done before abort (>=1)
// PORTS
//  clk        in   1         clock
//  Reset      in   1         sync, active-high; clears all state
//  start      in   1         request; accepted only in IDLE
//  P          in   curve_point_t  base point, latched on accept
//  k          in   SCALAR_W  scalar, latched on accept
//  busy       out  1         high from accept until Done
//  Done       out  1         level; high until next accepted start or Reset
//  Err        out  1         engine timeout; valid when Done
//  R          out  curve_point_t  result; stable while Done
//  R_inf      out  1         result is point at infinity (k==0)
//  dbl_reset  out  1         to point_double Reset (1-cycle kick)
//  dbl_P      out  curve_point_t  doubler operand (= acc)
//  dbl_R      in   curve_point_t  doubler result
//  dbl_done   in   1         doubler Done (level)
//  add_reset  out  1         to point_add Reset (1-cycle kick)
//  add_P      out  curve_point_t  adder operand 1 (= acc)
//  add_Q      out  curve_point_t  adder operand 2 (= latched P)
//  add_R      in   curve_point_t  adder result
//  add_done   in   1         adder Done (level)
// BEHAVIOUR
//  Reset (synchronous, active-high, clock clk): state=IDLE; busy,Done,Err,R_inf=0; R=0;
//   dbl_reset=add_reset=1 while Reset high (engines held idle); 0 after.
//  States: IDLE, SCAN, DBL_KICK, DBL_WAIT, ADD_KICK, ADD_WAIT, FINISH.
//  IDLE: start=1 -> latch P,k; busy=1; Done,Err,R_inf=0; ->SCAN. start elsewhere ignored.
//  SCAN (1 cycle): k==0 -> R_inf=1, ->FINISH. Else n=index of leading 1 (leading_one_finder),
//   acc<=P, i<=n-1; n==0 -> R=P, ->FINISH; else ->DBL_KICK.
//  DBL_KICK: dbl_reset=1 for exactly this cycle; clear timer; ->DBL_WAIT.
//  DBL_WAIT: dbl_done sampled 1 -> acc<=dbl_R; if k[i] ->ADD_KICK, else if i==0 ->FINISH,
//   else i--, ->DBL_KICK. Done from previous op must not be sampled: wait starts cycle after kick.
//  ADD_KICK/ADD_WAIT: same pattern with add_*; on add_done acc<=add_R; i==0 ->FINISH, else
//   i--, ->DBL_KICK.
//  FINISH (1 cycle): R<=acc (unless R_inf); Done=1; busy=0; ->IDLE.
//  Timeout: timer counts WAIT cycles; reaching TIMEOUT -> Err=1, Done=1, busy=0, R unchanged,
//   pulse the stuck engine's reset, ->IDLE.
//  dbl_P/add_P driven from acc register; held constant through KICK..WAIT.
//  Latency (accept->Done), n=leading-1 index, h=popcount(k), engine latencies Td/Ta
//   (kick-deassert to done sampled): 3 + n*(1+Td) + (h-1)*(1+Ta); k==0 or 1: 3 cycles.
//  Reset mid-operation: abort immediately, no Done, engines held in reset.
//  start same cycle as Done-driving FINISH: ignored (state not yet IDLE).
//  acc==+/-P inside add is not special-cased; add_R taken as-is.
// STRUCTURE
//  Package elliptic_curve_structs: add scalar_mul_state_t enum, SCALAR_W_DEFAULT.
//  Sub-module: leading_one_finder #(W) (comb priority encoder: any, idx[$clog2(W)-1:0]).
//  Engines stay outside so parent can share them with other clients.
// TESTING (stub engines: fixed Td=4, Ta=6; points model scalar multiples, x=multiple)
//  k=0 -> Done at accept+3, R_inf=1, no engine kicks.
//  k=1, P.x=1 -> Done at accept+3, R.x=1, no engine kicks.
//  k=5 -> kick order D,D,A; R.x=5; Done at 3+2*5+1*7=20 cycles.
//  k=6 -> kick order D,A,D; R.x=6; k=2^255 -> 255 D, 0 A, R.x=2^255.
//  Stub dbl_done never rises, TIMEOUT=16 -> Err=1, Done=1 at kick+17, back in IDLE.
//  Reset asserted in ADD_WAIT -> busy=0, Done=0 next cycle; start while busy ignored.

Source files
------------

// File: rtl/scalar_mul_sequencer_pkg.sv
// elliptic_curve_structs: shared curve point type and scalar-multiply sequencer states.
package elliptic_curve_structs;
   localparam int COORD_W = 256;
   localparam int SCALAR_W_DEFAULT = 256;
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } curve_point_t;
   typedef enum logic [2:0] {
      SM_IDLE,
      SM_SCAN,
      SM_DBL_KICK,
      SM_DBL_WAIT,
      SM_ADD_KICK,
      SM_ADD_WAIT,
      SM_FINISH
   } scalar_mul_state_t;
endpackage

// File: rtl/scalar_mul_sequencer_lof.sv
// leading_one_finder: combinational priority encoder returning the index of the highest set bit.
module leading_one_finder #(
   parameter int W = 256
) (
   input  logic [W-1:0]         vec_i,
   output logic                 any_o,
   output logic [$clog2(W)-1:0] idx_o
);
   assign any_o = |vec_i;
   always_comb begin
      idx_o = '0;
      for (int b = 0; b < W; b++) idx_o = vec_i[b] ? ($clog2(W))'(b) : idx_o;
   end
endmodule

// File: rtl/scalar_mul_sequencer.sv
// scalar_mul_sequencer: MSB-first double-and-add controller driving external shared
// point_double / point_add engines through their Reset-as-start / Done handshake.
module scalar_mul_sequencer
   import elliptic_curve_structs::*;
#(
   parameter int SCALAR_W = SCALAR_W_DEFAULT,
   parameter int TIMEOUT  = 65535
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                start,
   input  curve_point_t        P,
   input  logic [SCALAR_W-1:0] k,
   output logic                busy,
   output logic                Done,
   output logic                Err,
   output curve_point_t        R,
   output logic                R_inf,
   output logic                dbl_reset,
   output curve_point_t        dbl_P,
   input  curve_point_t        dbl_R,
   input  logic                dbl_done,
   output logic                add_reset,
   output curve_point_t        add_P,
   output curve_point_t        add_Q,
   input  curve_point_t        add_R,
   input  logic                add_done
);
   localparam int IW = $clog2(SCALAR_W);
   localparam int TW = $clog2(TIMEOUT + 1);
   scalar_mul_state_t state_q, state_d;
   curve_point_t p_q, p_d, acc_q, acc_d, r_q, r_d;
   logic [SCALAR_W-1:0] k_q, k_d;
   logic [IW-1:0] i_q, i_d, lead_idx;
   logic [TW-1:0] timer_q, timer_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d, r_inf_q, r_inf_d;
   logic lead_any, in_dbl, waiting, eng_done, last, abort;
   leading_one_finder #(.W(SCALAR_W)) u_lof (
      .vec_i(k_q),
      .any_o(lead_any),
      .idx_o(lead_idx)
   );
   assign in_dbl   = state_q == SM_DBL_WAIT;
   assign waiting  = in_dbl || state_q == SM_ADD_WAIT;
   assign eng_done = in_dbl ? dbl_done : add_done;
   assign last     = i_q == '0;
   assign abort    = waiting && !eng_done && timer_q == TW'(TIMEOUT - 1);
   // Engines are held in reset while we are reset, kicked for one cycle, and re-kicked on abort.
   assign dbl_reset = Reset || state_q == SM_DBL_KICK || (abort && in_dbl);
   assign add_reset = Reset || state_q == SM_ADD_KICK || (abort && !in_dbl);
   assign dbl_P = acc_q;
   assign add_P = acc_q;
   assign add_Q = p_q;
   assign busy  = busy_q;
   assign Done  = done_q;
   assign Err   = err_q;
   assign R     = r_q;
   assign R_inf = r_inf_q;
   always_comb begin
      state_d = state_q;
      p_d = p_q;
      k_d = k_q;
      acc_d = acc_q;
      i_d = i_q;
      timer_d = timer_q;
      busy_d = busy_q;
      done_d = done_q;
      err_d = err_q;
      r_d = r_q;
      r_inf_d = r_inf_q;
      case (state_q)
         SM_IDLE: if (start) begin
            p_d = P;
            k_d = k;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d = 1'b0;
            r_inf_d = 1'b0;
            state_d = SM_SCAN;
         end
         SM_SCAN: begin
            acc_d = p_q;
            i_d = lead_idx - 1'b1;
            r_inf_d = !lead_any;
            state_d = (lead_idx == '0) ? SM_FINISH : SM_DBL_KICK;
         end
         SM_DBL_KICK, SM_ADD_KICK: begin
            timer_d = '0;
            state_d = (state_q == SM_DBL_KICK) ? SM_DBL_WAIT : SM_ADD_WAIT;
         end
         SM_DBL_WAIT, SM_ADD_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (eng_done) begin
               acc_d = in_dbl ? dbl_R : add_R;
               i_d = ((in_dbl && k_q[i_q]) || last) ? i_q : i_q - 1'b1;
               state_d = (in_dbl && k_q[i_q]) ? SM_ADD_KICK : last ? SM_FINISH : SM_DBL_KICK;
            end else if (abort) begin
               err_d = 1'b1;
               done_d = 1'b1;
               busy_d = 1'b0;
               state_d = SM_IDLE;
            end
         end
         SM_FINISH: begin
            r_d = r_inf_q ? r_q : acc_q;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = SM_IDLE;
         end
         default: state_d = SM_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= SM_IDLE;
         p_q <= '0;
         k_q <= '0;
         acc_q <= '0;
         i_q <= '0;
         timer_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         r_q <= '0;
         r_inf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q <= p_d;
         k_q <= k_d;
         acc_q <= acc_d;
         i_q <= i_d;
         timer_q <= timer_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         r_q <= r_d;
         r_inf_q <= r_inf_d;
      end
   end
endmodule
